// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite request arbiter.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         MAX_REQ   = 8;

    // First requester at or after (last+1) mod n; returns last when nothing is requesting.
    function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic       found;
        logic [2:0] idx;
        rr_next = last;
        found   = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (!found && i <= n) begin
                idx = 3'((int'(last) + i) % n);
                if (req[idx]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/axil_req_arbiter_rr_arbiter.sv
// Round-robin grant selection with a registered last-grant pointer.
module rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IDX_W-1:0]   adv_idx,
    output logic [IDX_W-1:0]   grant,
    output logic               grant_vld
);

    logic [IDX_W-1:0]   last_grant;
    logic [MAX_REQ-1:0] req_pad;

    // Pad the request vector to the helper's fixed width and pick the next winner.
    always_comb begin
        req_pad   = MAX_REQ'(req);
        grant     = IDX_W'(rr_next(req_pad, 3'(last_grant), NUM_REQ));
        grant_vld = |req;
    end

    // Pointer starts at the last index so requester 0 wins first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= IDX_W'(NUM_REQ - 1);
        else if (advance)
            last_grant <= adv_idx;
    end

endmodule

// File: rtl/axil_req_arbiter.sv
// Shares one AXI4-Lite master among NUM_REQ req/ack requesters, one transaction at a time.
module axil_req_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                           axi_clk,
    input  logic                           axi_rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]             ack,
    output logic [DATA_W-1:0]              rdata,
    output logic                           err,
    output logic [ADDR_W-1:0]              m_axi_awaddr,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [DATA_W-1:0]              m_axi_wdata,
    output logic [DATA_W/8-1:0]            m_axi_wstrb,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic [ADDR_W-1:0]              m_axi_araddr,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [DATA_W-1:0]              m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     gidx, gidx_nxt;
    logic [IDX_W-1:0]     gnt;
    logic                 gnt_vld;
    logic                 advance;
    logic [ADDR_W-1:0]    cmd_addr, addr_nxt;
    logic [DATA_W-1:0]    cmd_wdata, wdata_nxt;
    logic                 awvalid_q, awvalid_nxt;
    logic                 wvalid_q, wvalid_nxt;
    logic                 bready_q, bready_nxt;
    logic                 arvalid_q, arvalid_nxt;
    logic                 rready_q, rready_nxt;
    logic [NUM_REQ-1:0]   ack_q, ack_nxt;
    logic [DATA_W-1:0]    rdata_q, rdata_nxt;
    logic                 err_q, err_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk       (axi_clk),
        .rst       (axi_rst),
        .req       (req),
        .advance   (advance),
        .adv_idx   (gidx),
        .grant     (gnt),
        .grant_vld (gnt_vld)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_nxt   = state;
        gidx_nxt    = gidx;
        addr_nxt    = cmd_addr;
        wdata_nxt   = cmd_wdata;
        awvalid_nxt = awvalid_q;
        wvalid_nxt  = wvalid_q;
        bready_nxt  = 1'b0;
        arvalid_nxt = 1'b0;
        rready_nxt  = 1'b0;
        ack_nxt     = '0;
        rdata_nxt   = rdata_q;
        err_nxt     = err_q;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    gidx_nxt  = gnt;
                    addr_nxt  = addr[gnt];
                    wdata_nxt = wdata[gnt];
                    if (we[gnt]) begin
                        state_nxt   = WRITE;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = READ;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; move on once neither is pending.
                if (awvalid_q && m_axi_awready) awvalid_nxt = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_nxt  = 1'b0;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = WRESP;
                    bready_nxt = 1'b1;
                end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    err_nxt   = (m_axi_bresp != RESP_OKAY);
                    ack_nxt   = NUM_REQ'(1) << gidx;
                    state_nxt = DONE;
                end else begin
                    bready_nxt = 1'b1;
                end
            end
            READ: begin
                if (m_axi_arready) begin
                    state_nxt  = RDATA;
                    rready_nxt = 1'b1;
                end else begin
                    arvalid_nxt = 1'b1;
                end
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    rdata_nxt = m_axi_rdata;
                    err_nxt   = (m_axi_rresp != RESP_OKAY);
                    ack_nxt   = NUM_REQ'(1) << gidx;
                    state_nxt = DONE;
                end else begin
                    rready_nxt = 1'b1;
                end
            end
            DONE: begin
                advance   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset clears every handshake line at once.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state     <= IDLE;
            gidx      <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            gidx      <= gidx_nxt;
            cmd_addr  <= addr_nxt;
            cmd_wdata <= wdata_nxt;
            awvalid_q <= awvalid_nxt;
            wvalid_q  <= wvalid_nxt;
            bready_q  <= bready_nxt;
            arvalid_q <= arvalid_nxt;
            rready_q  <= rready_nxt;
            ack_q     <= ack_nxt;
            rdata_q   <= rdata_nxt;
            err_q     <= err_nxt;
        end
    end

    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign m_axi_awaddr  = cmd_addr;
    assign m_axi_araddr  = cmd_addr;
    assign m_axi_wdata   = cmd_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
